// File: rtl/let_fp_calc.sv
// Two-stage signed Q(I.F) complex add/sub/mul calculator with optional scale-down.
// Define LET_FP_SAT_EN to saturate on narrowing; otherwise results wrap to W bits.
module let_fp_calc #(
    parameter int I = 4,
    parameter int F = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic             sc,
    input  logic [I+F-1:0]   a_re,
    input  logic [I+F-1:0]   a_im,
    input  logic [I+F-1:0]   b_re,
    input  logic [I+F-1:0]   b_im,
    output logic             out_valid,
    output logic [I+F-1:0]   r_re,
    output logic [I+F-1:0]   r_im
);

    localparam int W = I + F;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_CMUL = 2'b10;
    localparam logic [1:0] OP_RMUL = 2'b11;

    logic signed [W-1:0]   ar_s, ai_s, br_s, bi_s;
    logic signed [W:0]     sum_re, sum_im, dif_re, dif_im;
    logic signed [2*W-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [2*W-1:0] wre_d, wim_d;

    logic                  v1_q;
    logic [1:0]            op1_q;
    logic                  sc1_q;
    logic signed [2*W-1:0] wre1_q, wim1_q;

    logic signed [2*W-1:0] pre_re, pre_im, sh_re, sh_im;
    logic [W-1:0]          r_re_d, r_im_d;

    logic                  v2_q;
    logic [W-1:0]          r_re_q, r_im_q;

    assign ar_s = a_re;
    assign ai_s = a_im;
    assign br_s = b_re;
    assign bi_s = b_im;

    assign sum_re = {ar_s[W-1], ar_s} + {br_s[W-1], br_s};
    assign sum_im = {ai_s[W-1], ai_s} + {bi_s[W-1], bi_s};
    assign dif_re = {ar_s[W-1], ar_s} - {br_s[W-1], br_s};
    assign dif_im = {ai_s[W-1], ai_s} - {bi_s[W-1], bi_s};

    assign p_rr = ar_s * br_s;
    assign p_ii = ai_s * bi_s;
    assign p_ri = ar_s * bi_s;
    assign p_ir = ai_s * br_s;

    // Add/sub results are sign-extended so both paths share one 2W-wide stage register.
    always_comb begin
        wre_d = '0;
        wim_d = '0;
        case (op)
            OP_ADD: begin
                wre_d = {{(W-1){sum_re[W]}}, sum_re};
                wim_d = {{(W-1){sum_im[W]}}, sum_im};
            end
            OP_SUB: begin
                wre_d = {{(W-1){dif_re[W]}}, dif_re};
                wim_d = {{(W-1){dif_im[W]}}, dif_im};
            end
            OP_CMUL: begin
                wre_d = p_rr - p_ii;
                wim_d = p_ri + p_ir;
            end
            OP_RMUL: begin
                wre_d = p_rr;
                wim_d = '0;
            end
            default: begin
                wre_d = '0;
                wim_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            op1_q  <= '0;
            sc1_q  <= 1'b0;
            wre1_q <= '0;
            wim1_q <= '0;
        end else begin
            v1_q   <= in_valid;
            op1_q  <= op;
            sc1_q  <= sc;
            wre1_q <= wre_d;
            wim1_q <= wim_d;
        end
    end

    always_comb begin
        pre_re = wre1_q;
        pre_im = wim1_q;
        if ((op1_q == OP_CMUL) || (op1_q == OP_RMUL)) begin
            pre_re = wre1_q >>> F;
            pre_im = wim1_q >>> F;
        end
        sh_re = sc1_q ? (pre_re >>> 1) : pre_re;
        sh_im = sc1_q ? (pre_im >>> 1) : pre_im;
    end

`ifdef LET_FP_SAT_EN
    function automatic logic [W-1:0] narrow(input logic signed [2*W-1:0] x);
        logic [W:0] top;
        top = x[2*W-1:W-1];
        if ((&top) || !(|top))
            return x[W-1:0];
        else if (x[2*W-1])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

    always_comb begin
        r_re_d = narrow(sh_re);
        r_im_d = narrow(sh_im);
    end
`else
    always_comb begin
        r_re_d = W'(sh_re);
        r_im_d = W'(sh_im);
    end
`endif

    // Results only update on valid stage-1 data so idle cycles hold the last output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            r_re_q <= '0;
            r_im_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                r_re_q <= r_re_d;
                r_im_q <= r_im_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign r_re      = r_re_q;
    assign r_im      = r_im_q;

endmodule

// File: tb/tb_let_fp_calc.sv
// Self-checking bench for let_fp_calc: directed vector table, streaming/reset sequences,
// and randomized traffic scored against an integer-arithmetic reference model.
module tb_let_fp_calc;

    localparam int I = 4;
    localparam int F = 12;
    localparam int W = I + F;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [1:0]   op = '0;
    logic         sc = 1'b0;
    logic [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
    logic         out_valid;
    logic [W-1:0] r_re, r_im;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic rst_seen = 1'b0;

    typedef struct {
        int           cyc;
        logic [W-1:0] er;
        logic [W-1:0] ei;
    } exp_t;
    exp_t sb[$];

    logic [W-1:0] last_re = '0, last_im = '0;
    int run_len = 0;
    int last_run = 0;

    let_fp_calc #(.I(I), .F(F)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .sc(sc),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .r_re(r_re), .r_im(r_im)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst_n;
    end

    function automatic longint wrap2w(input longint x);
        return (x <<< (64 - 2*W)) >>> (64 - 2*W);
    endfunction

    function automatic logic [W-1:0] narrow(input longint x);
        longint lo, hi;
        lo = -(longint'(1) <<< (W-1));
        hi = (longint'(1) <<< (W-1)) - 1;
`ifdef LET_FP_SAT_EN
        if (x > hi) x = hi;
        if (x < lo) x = lo;
`endif
        return x[W-1:0];
    endfunction

    // Reference: exact integer arithmetic, 2W wrap on products, floor shift, then narrow.
    function automatic void ref_model(input logic [1:0] o, input logic s,
                                      input logic signed [W-1:0] ar, ai, br, bi,
                                      output logic [W-1:0] rr, ri);
        longint xr, xi;
        int sh;
        case (o)
            2'd0: begin xr = longint'(ar) + longint'(br); xi = longint'(ai) + longint'(bi); end
            2'd1: begin xr = longint'(ar) - longint'(br); xi = longint'(ai) - longint'(bi); end
            2'd2: begin
                xr = wrap2w(longint'(ar) * longint'(br) - longint'(ai) * longint'(bi));
                xi = wrap2w(longint'(ar) * longint'(bi) + longint'(ai) * longint'(br));
            end
            default: begin xr = wrap2w(longint'(ar) * longint'(br)); xi = 0; end
        endcase
        sh = ((o >= 2'd2) ? F : 0) + (s ? 1 : 0);
        rr = narrow(xr >>> sh);
        ri = narrow(xi >>> sh);
    endfunction

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic s,
                         input logic [W-1:0] ar, ai, br, bi);
        exp_t e;
        in_valid = v; op = o; sc = s;
        a_re = ar; a_im = ai; b_re = br; b_im = bi;
        if (v && rst_n) begin
            e.cyc = cyc;
            ref_model(o, s, ar, ai, br, bi, e.er, e.ei);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 2'd0, 1'b0, '0, '0, '0, '0);
    endtask

    // Scoreboard: each accepted op must emerge exactly two cycles later, in order.
    always @(negedge clk) begin
        exp_t e;
        logic expv;
        if (!rst_seen) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) void'(sb.pop_front());
            last_re = '0; last_im = '0;
            run_len = 0;
            chk("reset_valid", {{(W-1){1'b0}}, out_valid}, '0);
            chk("reset_re", r_re, '0);
            chk("reset_im", r_im, '0);
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc - 2) begin
                checks++; errors++;
                $display("FAIL missing_result: got nothing expected op from cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
            expv = (sb.size() > 0) && (sb[0].cyc == cyc - 2);
            chk("out_valid", {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, expv});
            if (expv) begin
                e = sb.pop_front();
                chk("sb_re", r_re, e.er);
                chk("sb_im", r_im, e.ei);
                last_re = e.er; last_im = e.ei;
            end else begin
                chk("hold_re", r_re, last_re);
                chk("hold_im", r_im, last_im);
            end
            if (out_valid) run_len++;
            else begin
                if (run_len > 0) last_run = run_len;
                run_len = 0;
            end
        end
    end

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic         sc;
        logic [W-1:0] ar, ai, br, bi;
        logic [W-1:0] er, ei;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"add",      2'd0, 1'b0, 16'h1800, 16'h0000, 16'h0400, 16'h0000, 16'h1C00, 16'h0000};
        tbl[1] = '{"add_sc",   2'd0, 1'b1, 16'h1800, 16'h0000, 16'h0400, 16'h0000, 16'h0E00, 16'h0000};
        tbl[2] = '{"sub",      2'd1, 1'b0, 16'h0800, 16'h0800, 16'h1000, 16'h0000, 16'hF800, 16'h0800};
        tbl[3] = '{"cmul",     2'd2, 1'b0, 16'h1000, 16'h1000, 16'h1000, 16'hF000, 16'h2000, 16'h0000};
        tbl[4] = '{"cmul_sc",  2'd2, 1'b1, 16'h1000, 16'h1000, 16'h1000, 16'hF000, 16'h1000, 16'h0000};
`ifdef LET_FP_SAT_EN
        tbl[5] = '{"ovf_add",  2'd0, 1'b0, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'h7FFF, 16'h0000};
        tbl[6] = '{"ovf_rmul", 2'd3, 1'b0, 16'h8000, 16'h1234, 16'h8000, 16'h4321, 16'h7FFF, 16'h0000};
`else
        tbl[5] = '{"ovf_add",  2'd0, 1'b0, 16'h7000, 16'h0000, 16'h7000, 16'h0000, 16'hE000, 16'h0000};
        tbl[6] = '{"ovf_rmul", 2'd3, 1'b0, 16'h8000, 16'h1234, 16'h8000, 16'h4321, 16'h0000, 16'h0000};
`endif
        tbl[7] = '{"sub_floor", 2'd1, 1'b1, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000};

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Directed vectors, each isolated so latency and value are checked at a fixed cycle.
        for (int t = 0; t < 8; t++) begin
            drive(1'b1, tbl[t].op, tbl[t].sc, tbl[t].ar, tbl[t].ai, tbl[t].br, tbl[t].bi);
            drive(1'b0, 2'd0, 1'b0, '0, '0, '0, '0);
            @(negedge clk);
            chk({tbl[t].name, "_valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, 1'b1});
            chk({tbl[t].name, "_re"}, r_re, tbl[t].er);
            chk({tbl[t].name, "_im"}, r_im, tbl[t].ei);
            @(posedge clk);
            #1;
            idle(1);
        end

        // Eight back-to-back ops with mixed op/sc must give one unbroken run of eight.
        for (int t = 0; t < 8; t++)
            drive(1'b1, 2'(t % 4), 1'(t / 4), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        idle(4);
        checks++;
        if (last_run != 8) begin
            errors++;
            $display("FAIL stream_run: got %0d expected 8", last_run);
        end

        // Reset mid-stream: in-flight ops are dropped and outputs clear on the next edge.
        for (int t = 0; t < 4; t++)
            drive(1'b1, 2'(t % 4), 1'b0, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        rst_n = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 16'h1000, 16'h1000, 16'h1000, 16'h1000);
        rst_n = 1'b1;
        chk("midrst_valid", {{(W-1){1'b0}}, out_valid}, '0);
        chk("midrst_re", r_re, '0);
        chk("midrst_im", r_im, '0);
        idle(3);
        drive(1'b1, 2'd0, 1'b0, 16'h1800, 16'h0000, 16'h0400, 16'h0000);
        idle(3);
        chk("post_rst_re", r_re, 16'h1C00);

        // Randomized traffic with occasional extreme operands and one reset.
        for (int t = 0; t < 400; t++) begin
            logic [W-1:0] ops[4];
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 5))
                    0: ops[k] = 16'h8000;
                    1: ops[k] = 16'h7FFF;
                    default: ops[k] = W'($urandom);
                endcase
            end
            if (t == 200) rst_n = 1'b0;
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ops[0], ops[1], ops[2], ops[3]);
            rst_n = 1'b1;
        end
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
